// File: rtl/alu_result_collector.sv
// Write-back collector: picks the flagged ALU unit (ARITH > LOGIC > CMP > SHIFT), tags the
// result with its source and queues it in a show-ahead FIFO drained by a valid/ready handshake.
module alu_result_collector #(
    parameter int unsigned OutWidth = 16,
    parameter int unsigned Depth    = 4,
    localparam int unsigned AddrW   = $clog2(Depth),
    localparam int unsigned CntW    = $clog2(Depth) + 1
) (
    input  logic                i_clk_coll,
    input  logic                i_rst_coll,
    input  logic [OutWidth-1:0] i_arith_out_coll,
    input  logic                i_arith_flag_coll,
    input  logic [OutWidth-1:0] i_logic_out_coll,
    input  logic                i_logic_flag_coll,
    input  logic [OutWidth-1:0] i_cmp_out_coll,
    input  logic                i_cmp_flag_coll,
    input  logic [OutWidth-1:0] i_shift_out_coll,
    input  logic                i_shift_flag_coll,
    output logic [OutWidth-1:0] o_res_data,
    output logic [1:0]          o_res_src,
    output logic                o_res_valid,
    input  logic                i_res_ready,
    output logic [CntW-1:0]     o_res_count,
    output logic                o_fifo_full,
    output logic                o_fifo_empty,
    output logic                o_overflow_err,
    output logic                o_collision_err
);

    logic [OutWidth+1:0] r_mem [Depth];
    logic [AddrW-1:0]    r_wr_ptr;
    logic [AddrW-1:0]    r_rd_ptr;
    logic [CntW-1:0]     r_count;
    logic                r_overflow_err;
    logic                r_collision_err;

    logic [OutWidth-1:0] w_sel_data;
    logic [1:0]          w_sel_src;
    logic                w_any;
    logic                w_collision;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic [2:0]          w_nflags;

    always_comb begin
        w_sel_data = '0;
        w_sel_src  = 2'b00;
        if (i_arith_flag_coll) begin
            w_sel_data = i_arith_out_coll;
            w_sel_src  = 2'b00;
        end else if (i_logic_flag_coll) begin
            w_sel_data = i_logic_out_coll;
            w_sel_src  = 2'b01;
        end else if (i_cmp_flag_coll) begin
            w_sel_data = i_cmp_out_coll;
            w_sel_src  = 2'b10;
        end else if (i_shift_flag_coll) begin
            w_sel_data = i_shift_out_coll;
            w_sel_src  = 2'b11;
        end
    end

    assign w_nflags    = {2'b00, i_arith_flag_coll} + {2'b00, i_logic_flag_coll}
                       + {2'b00, i_cmp_flag_coll} + {2'b00, i_shift_flag_coll};
    assign w_any       = (w_nflags != 3'd0);
    assign w_collision = (w_nflags > 3'd1);
    assign w_full      = (r_count == CntW'(Depth));
    assign w_empty     = (r_count == '0);
    assign w_pop       = !w_empty && i_res_ready;
    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign w_push      = w_any && (!w_full || w_pop);
    assign w_drop      = w_any && w_full && !w_pop;

    always_ff @(posedge i_clk_coll) begin
        if (i_rst_coll) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_overflow_err  <= 1'b0;
            r_collision_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {w_sel_src, w_sel_data};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop) begin
                r_overflow_err <= 1'b1;
            end
            if (w_collision) begin
                r_collision_err <= 1'b1;
            end
        end
    end

    logic [OutWidth+1:0] w_head;
    assign w_head = r_mem[r_rd_ptr];

    assign o_res_data      = w_empty ? '0 : w_head[OutWidth-1:0];
    assign o_res_src       = w_empty ? 2'b00 : w_head[OutWidth+1:OutWidth];
    assign o_res_valid     = !w_empty;
    assign o_res_count     = r_count;
    assign o_fifo_full     = w_full;
    assign o_fifo_empty    = w_empty;
    assign o_overflow_err  = r_overflow_err;
    assign o_collision_err = r_collision_err;

endmodule
